// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the register file, bypasses writebacks, tracks
// pending destinations in a busy scoreboard and holds one entry for execute.
module operand_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [3:0]  in_rd,
    input  logic        in_wr,
    input  logic [3:0]  in_rs1,
    input  logic [3:0]  in_rs2,
    input  logic        in_use_imm,
    input  logic [19:0] in_imm,
    output logic [3:0]  r1_select,
    output logic [3:0]  r2_select,
    input  logic [19:0] read1,
    input  logic [19:0] read2,
    input  logic        wb_en,
    input  logic [3:0]  wb_select,
    input  logic [19:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_opcode,
    output logic [3:0]  out_rd,
    output logic        out_wr,
    output logic [19:0] out_a,
    output logic [19:0] out_b
);

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic        wr;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        use_imm;
        logic [19:0] a;
        logic [19:0] b;
    } entry_t;

    entry_t      entry_q, entry_d;
    logic        valid_q, valid_d;
    logic [15:0] busy_q, busy_d;
    logic [15:0] clr;
    logic [15:0] busy_eff;
    logic        hazard;
    logic        accept;
    logic        deq;

    assign r1_select = in_rs1;
    assign r2_select = in_rs2;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        clr = '0;
        if (wb_en) clr[wb_select] = 1'b1;
    end

    // A writeback this cycle resolves the hazard this cycle.
    assign busy_eff = busy_q & ~clr;
    assign hazard   = busy_eff[in_rs1]
                    | (~in_use_imm & busy_eff[in_rs2])
                    | (in_wr & busy_eff[in_rd]);
    assign in_ready = (~valid_q | out_ready) & ~hazard;
    assign accept   = in_valid & in_ready;
    assign deq      = valid_q & out_ready;

    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        if (accept) begin
            valid_d         = 1'b1;
            entry_d.opcode  = in_opcode;
            entry_d.rd      = in_rd;
            entry_d.wr      = in_wr;
            entry_d.rs1     = in_rs1;
            entry_d.rs2     = in_rs2;
            entry_d.use_imm = in_use_imm;
            entry_d.a       = clr[in_rs1] ? wb_data : read1;
            entry_d.b       = in_use_imm ? in_imm : (clr[in_rs2] ? wb_data : read2);
        end else if (deq) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled entry keeps snooping writebacks instead of re-reading.
            if (clr[entry_q.rs1])                     entry_d.a = wb_data;
            if (clr[entry_q.rs2] && !entry_q.use_imm) entry_d.b = wb_data;
        end
    end

    always_comb begin
        busy_d = busy_q & ~clr;
        if (accept && in_wr) busy_d[in_rd] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_opcode = entry_q.opcode;
    assign out_rd     = entry_q.rd;
    assign out_wr     = entry_q.wr;
    assign out_a      = entry_q.a;
    assign out_b      = entry_q.b;

endmodule
